// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: port ids and the command-stage control record.
package ram_arb_pkg;

    localparam logic ID_M0 = 1'b0;
    localparam logic ID_M1 = 1'b1;

    // The command stage pairs this record with the address/write-data registers of the top.
    typedef struct packed {
        logic valid;
        logic we;
        logic id;
    } cmd_ctrl_t;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin picker; the registered pointer remembers the last winner.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    logic r_last;

    // On a tie, the port that did not win last time gets the grant.
    always_comb begin
        o_gnt = 2'b00;
        if (&i_req) begin
            o_gnt = (r_last == ID_M1) ? 2'b01 : 2'b10;
        end else begin
            o_gnt = i_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= ID_M1;
        end else if (|o_gnt) begin
            r_last <= o_gnt[ID_M1];
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between M0 (CPU) and M1 (loader).
// Optional M1 write protection above WP_BASE is enabled by defining RAM_ARB_WPROT_EN.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] WP_BASE    = 8'hC0
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic                  m1_err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

`ifdef RAM_ARB_WPROT_EN
    localparam logic WPROT_ON = 1'b1;
`else
    localparam logic WPROT_ON = 1'b0;
`endif

    logic [1:0]            w_gnt;
    logic                  w_any;
    logic                  w_sel;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_prot;

    cmd_ctrl_t             r_cmd;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_err;
    logic                  r_rv0;
    logic                  r_rv1;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .i_req ({m1_req, m0_req}),
        .o_gnt (w_gnt)
    );

    assign m0_gnt  = w_gnt[ID_M0];
    assign m1_gnt  = w_gnt[ID_M1];
    assign w_any   = |w_gnt;
    assign w_sel   = w_gnt[ID_M1];
    assign w_we    = w_sel ? m1_we    : m0_we;
    assign w_addr  = w_sel ? m1_addr  : m0_addr;
    assign w_wdata = w_sel ? m1_wdata : m0_wdata;

    // A protected M1 write is still granted and kept as a write (so it never returns rvalid).
    assign w_prot  = WPROT_ON & w_gnt[ID_M1] & m1_we & (m1_addr >= WP_BASE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_cmd.valid <= w_any;
            r_cmd.we    <= w_any & w_we;
            r_cmd.id    <= w_sel;
            r_err       <= w_prot;
            if (w_any) begin
                r_addr  <= w_addr;
                r_wdata <= w_wdata;
            end
        end
    end

    // The RAM registers its read during the command cycle, so the valid is delayed by one more stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rv0 <= 1'b0;
            r_rv1 <= 1'b0;
        end else begin
            r_rv0 <= r_cmd.valid & ~r_cmd.we & (r_cmd.id == ID_M0);
            r_rv1 <= r_cmd.valid & ~r_cmd.we & (r_cmd.id == ID_M1);
        end
    end

    assign ram_we    = r_cmd.valid & r_cmd.we & ~r_err;
    assign ram_addr  = r_addr;
    assign ram_din   = r_wdata;
    assign m1_err    = r_err;
    assign m0_rvalid = r_rv0;
    assign m1_rvalid = r_rv1;
    assign rdata     = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural single-port RAM.
module tb_ram_arbiter;

`ifdef RAM_ARB_WPROT_EN
    localparam logic PROT = 1'b1;
`else
    localparam logic PROT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       m0_req, m0_we, m1_req, m1_we;
    logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic       m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, m1_err;
    logic [7:0] rdata;
    logic       ram_we;
    logic [7:0] ram_addr, ram_din, ram_dout;
    logic [7:0] mem [256];

    int vecs = 0;
    int errs = 0;

    ram_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_err    (m1_err),
        .rdata     (rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    always #5 clk = ~clk;

    // Single-port RAM: registered read, read only when not writing.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        else        ram_dout <= mem[ram_addr];
    end

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("[TB] FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                                 input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
        #1;
    endtask

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       expRv0, expRv1;
        logic [7:0] expData;
        int         k;

        rst_n = 1'b0;
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        #11;
        checkBit("rst_ram_we", ram_we, 1'b0);
        checkOutput("rst_ram_addr", ram_addr, 8'h00);
        checkOutput("rst_ram_din", ram_din, 8'h00);
        checkBit("rst_m0_rvalid", m0_rvalid, 1'b0);
        checkBit("rst_m1_rvalid", m1_rvalid, 1'b0);
        checkBit("rst_m1_err", m1_err, 1'b0);
        rst_n = 1'b1;

        // M0 write 0x10 <- 0xA5, then read it back
        nextCycle;
        applyStimulus(1, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00);
        checkBit("a1_m0_gnt", m0_gnt, 1'b1);
        checkBit("a1_m1_gnt", m1_gnt, 1'b0);
        nextCycle;
        applyStimulus(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
        checkBit("a2_m0_gnt", m0_gnt, 1'b1);
        checkBit("a2_ram_we", ram_we, 1'b1);
        checkOutput("a2_ram_addr", ram_addr, 8'h10);
        checkOutput("a2_ram_din", ram_din, 8'hA5);
        nextCycle;
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        checkBit("a3_m0_gnt", m0_gnt, 1'b0);
        checkBit("a3_ram_we", ram_we, 1'b0);
        checkOutput("a3_ram_addr", ram_addr, 8'h10);
        checkBit("a3_m0_rvalid", m0_rvalid, 1'b0);
        nextCycle;
        checkBit("a4_m0_rvalid", m0_rvalid, 1'b1);
        checkBit("a4_m1_rvalid", m1_rvalid, 1'b0);
        checkOutput("a4_rdata", rdata, 8'hA5);

        // M1 alone for three cycles: two writes and a read of 0x10
        nextCycle;
        applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 8'h01, 8'h3C);
        checkBit("c1_m1_gnt", m1_gnt, 1'b1);
        checkBit("c1_m0_gnt", m0_gnt, 1'b0);
        nextCycle;
        applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 8'h02, 8'h4D);
        checkBit("c2_m1_gnt", m1_gnt, 1'b1);
        checkBit("c2_ram_we", ram_we, 1'b1);
        checkOutput("c2_ram_addr", ram_addr, 8'h01);
        checkOutput("c2_ram_din", ram_din, 8'h3C);
        nextCycle;
        applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00);
        checkBit("c3_m1_gnt", m1_gnt, 1'b1);
        checkBit("c3_m0_gnt", m0_gnt, 1'b0);

        // Both read continuously for six cycles; pointer is M1 so M0 goes first
        for (int i = 0; i < 8; i++) begin
            nextCycle;
            if (i < 6) applyStimulus(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00);
            else       applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
            checkBit($sformatf("b%0d_m0_gnt", i), m0_gnt, (i < 6) && (i % 2 == 0));
            checkBit($sformatf("b%0d_m1_gnt", i), m1_gnt, (i < 6) && (i % 2 == 1));
            expRv0 = 1'b0; expRv1 = 1'b0; expData = 8'h00;
            if (i == 1) begin
                expRv1 = 1'b1; expData = 8'hA5;
            end else if (i >= 2) begin
                k = i - 2;
                expRv0 = (k % 2 == 0);
                expRv1 = (k % 2 == 1);
                expData = (k % 2 == 0) ? 8'h3C : 8'h4D;
            end
            checkBit($sformatf("b%0d_m0_rvalid", i), m0_rvalid, expRv0);
            checkBit($sformatf("b%0d_m1_rvalid", i), m1_rvalid, expRv1);
            if (expRv0 || expRv1) checkOutput($sformatf("b%0d_rdata", i), rdata, expData);
        end

        // Reset pulsed in the cycle after an M0 read grant
        nextCycle;
        applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 8'h40, 8'h66);
        checkBit("d0_m1_gnt", m1_gnt, 1'b1);
        nextCycle;
        applyStimulus(1, 0, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00);
        checkBit("d1_m0_gnt", m0_gnt, 1'b1);
        checkBit("d1_ram_we", ram_we, 1'b1);
        checkOutput("d1_ram_addr", ram_addr, 8'h40);
        nextCycle;
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        rst_n = 1'b0;
        #1;
        checkBit("d2_ram_we", ram_we, 1'b0);
        checkOutput("d2_ram_addr", ram_addr, 8'h00);
        checkOutput("d2_ram_din", ram_din, 8'h00);
        nextCycle;
        checkBit("d3_m0_rvalid", m0_rvalid, 1'b0);
        rst_n = 1'b1;
        nextCycle;
        applyStimulus(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00);
        checkBit("d4_m0_rvalid", m0_rvalid, 1'b0);
        checkBit("d4_m1_rvalid", m1_rvalid, 1'b0);
        checkBit("d4_m0_gnt", m0_gnt, 1'b1);
        checkBit("d4_m1_gnt", m1_gnt, 1'b0);
        nextCycle;
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        nextCycle;
        checkBit("d6_m0_rvalid", m0_rvalid, 1'b1);
        checkOutput("d6_rdata", rdata, 8'h3C);

        // M1 write into the protected window, read back, then write just below it
        nextCycle;
        applyStimulus(1, 1, 8'hC0, 8'h11, 0, 0, 8'h00, 8'h00);
        checkBit("e1_m0_gnt", m0_gnt, 1'b1);
        nextCycle;
        applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 8'hC0, 8'h55);
        checkBit("e2_m1_gnt", m1_gnt, 1'b1);
        checkBit("e2_ram_we", ram_we, 1'b1);
        checkOutput("e2_ram_addr", ram_addr, 8'hC0);
        nextCycle;
        applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 8'hC0, 8'h00);
        checkBit("e3_m1_gnt", m1_gnt, 1'b1);
        checkBit("e3_ram_we", ram_we, !PROT);
        checkBit("e3_m1_err", m1_err, PROT);
        nextCycle;
        applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 8'hBF, 8'h77);
        checkBit("e4_m1_gnt", m1_gnt, 1'b1);
        checkBit("e4_ram_we", ram_we, 1'b0);
        checkBit("e4_m1_err", m1_err, 1'b0);
        nextCycle;
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        checkBit("e5_ram_we", ram_we, 1'b1);
        checkOutput("e5_ram_addr", ram_addr, 8'hBF);
        checkOutput("e5_ram_din", ram_din, 8'h77);
        checkBit("e5_m1_err", m1_err, 1'b0);
        checkBit("e5_m1_rvalid", m1_rvalid, 1'b1);
        checkOutput("e5_rdata", rdata, PROT ? 8'h11 : 8'h55);
        nextCycle;
        checkBit("e6_m1_rvalid", m1_rvalid, 1'b0);
        checkBit("e6_ram_we", ram_we, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
